// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Parametrised single-clock FIFO for command and data staging.
//   It supports show-ahead (FWFT=1) and standard 1-cycle-latency (FWFT=0) read modes.
//   All flags and the occupancy count are registers loaded from the next-state count.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous reset, active low
//   clr           synchronous flush; takes priority over wr_en/rd_en
//   wr_data       write data
//   wr_en         write request
//   full          count == DEPTH
//   almost_full   count >= ALMOST_FULL_NUM
//   overflow      1-cycle pulse when a write is dropped
//   rd_data       read data (head word in FWFT mode, popped word otherwise)
//   rd_en         read request (pop)
//   empty         count == 0
//   almost_empty  count <= ALMOST_EMPTY_NUM
//   underflow     1-cycle pulse when a read is dropped
//   data_cnt      words held, 0..DEPTH
module sync_fifo_fwft #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 4,
    parameter int FWFT             = 1,
    parameter int ALMOST_FULL_NUM  = 14,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  empty_q, empty_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance uses only the registered flags, never same-cycle requests.
    always_comb begin
        wr_ok = wr_en & ~full_q  & ~clr;
        rd_ok = rd_en & ~empty_q & ~clr;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + ONE_C;
            if (rd_ok) rd_ptr_d = rd_ptr_q + ONE_C;
            if (wr_ok && !rd_ok)      cnt_d = cnt_q + ONE_C;
            else if (rd_ok && !wr_ok) cnt_d = cnt_q - ONE_C;
        end

        if (FWFT != 0) begin
            // Show-ahead: load the head word as it will be after this edge.
            // When the new head is the slot being written right now
            // (queue otherwise empty), the memory does not hold it yet,
            // so it is taken straight from wr_data.
            if (!clr && cnt_d != '0) begin
                if (wr_ok && rd_ptr_d == wr_ptr_q)
                    rd_data_d = wr_data;
                else
                    rd_data_d = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
            end
        end else begin
            if (rd_ok) rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end

        full_d   = (cnt_d == DEPTH_C);
        afull_d  = (cnt_d >= AF_C);
        empty_d  = (cnt_d == '0);
        aempty_d = (cnt_d <= AE_C);
        ovf_d    = wr_en & full_q  & ~clr;
        unf_d    = rd_en & empty_q & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
    end

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign underflow    = unf_q;
    assign data_cnt     = cnt_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFN   = 14;
    localparam int AEN   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          full, almost_full, overflow;
    logic          empty, almost_empty, underflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   data_cnt;

    sync_fifo_fwft #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .FWFT(1),
        .ALMOST_FULL_NUM(AFN),
        .ALMOST_EMPTY_NUM(AEN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .full(full),
        .almost_full(almost_full),
        .overflow(overflow),
        .rd_data(rd_data),
        .rd_en(rd_en),
        .empty(empty),
        .almost_empty(almost_empty),
        .underflow(underflow),
        .data_cnt(data_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of stored words, with the head word shown on rd_data.
    logic [DW-1:0] mq [$];
    logic [DW-1:0] exp_rd = '0;
    logic          exp_ov = 1'b0;
    logic          exp_un = 1'b0;

    logic [42:0] obs;
    assign obs = {empty, almost_empty, full, almost_full, overflow, underflow, data_cnt, rd_data};

    function automatic logic [42:0] exp_vec();
        int n = mq.size();
        return {n == 0, n <= AEN, n == DEPTH, n >= AFN, exp_ov, exp_un, 5'(n), exp_rd};
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_rd = '0;
        exp_ov = 1'b0;
        exp_un = 1'b0;
    endtask

    // One clock cycle of stimulus; the model advances by queue rules at the edge.
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit was_full, was_empty;
        wr_en = w; rd_en = r; clr = c; wr_data = d;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (c) begin
            mq.delete();
            exp_ov = 1'b0;
            exp_un = 1'b0;
        end else begin
            exp_ov = w && was_full;
            exp_un = r && was_empty;
            if (r && !was_empty) void'(mq.pop_front());
            if (w && !was_full)  mq.push_back(d);
        end
        if (mq.size() > 0) exp_rd = mq[0];
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #11;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_single_word();
        step(1'b1, 1'b0, 1'b0, 32'hA5A5_0001);
        checks++;
        if (rd_data !== 32'hA5A5_0001 || empty !== 1'b0 || data_cnt !== 5'd1) begin
            errors++;
            $display("FAIL single_show got rd=%h empty=%b cnt=%0d exp rd=a5a50001 empty=0 cnt=1",
                     rd_data, empty, data_cnt);
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (empty !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_pop got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(i));
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL fill word=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        checks++;
        if (overflow !== 1'b1 || data_cnt !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got ov=%b cnt=%0d full=%b exp ov=1 cnt=16 full=1",
                     overflow, data_cnt, full);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        checks++;
        if (overflow !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL fill_ov_pulse got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL drain rd=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (underflow !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_underflow got un=%b empty=%b exp un=1 empty=1", underflow, empty);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, $urandom);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL simul_fill word=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        step(1'b1, 1'b1, 1'b0, $urandom);
        checks++;
        if (data_cnt !== 5'd15 || overflow !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL simul_full got=%h exp=%h", obs, exp_vec());
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL simul_drain rd=%0d got=%h exp=%h", i, obs, exp_vec());
            end
        end
        step(1'b1, 1'b1, 1'b0, 32'h1234_5678);
        checks++;
        if (data_cnt !== 5'd1 || underflow !== 1'b1 || rd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL simul_empty got cnt=%0d un=%b rd=%h exp cnt=1 un=1 rd=12345678",
                     data_cnt, underflow, rd_data);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0BAD_F00D);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL simul_cnt1 got=%h exp=%h", obs, exp_vec());
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL simul_last got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap_stream();
        int written = 0;
        int cyc = 0;
        logic w, r;
        while (written < 40 && cyc < 400) begin
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w && mq.size() < DEPTH) written++;
            step(w, r, 1'b0, $urandom);
            cyc++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
        end
        checks++;
        if (written < 40) begin
            errors++;
            $display("FAIL stream_budget got=%0d words exp=40", written);
        end
        cyc = 0;
        while (mq.size() > 0 && cyc < 40) begin
            step(1'b0, 1'b1, 1'b0, '0);
            cyc++;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL stream_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        checks++;
        if (data_cnt !== 5'd9 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL clr_pre got=%h exp=%h", obs, exp_vec());
        end
        step(1'b1, 1'b1, 1'b1, $urandom);
        checks++;
        if (data_cnt !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0
            || obs !== exp_vec()) begin
            errors++;
            $display("FAIL clr got=%h exp=%h", obs, exp_vec());
        end
        step(1'b1, 1'b0, 1'b0, 32'hC0DE_0001);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL clr_after got=%h exp=%h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, $urandom);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", obs, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if (underflow !== 1'b1 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_after got=%h exp=%h", obs, exp_vec());
        end
        step(1'b1, 1'b0, 1'b0, 32'h7777_0001);
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_mid_write got=%h exp=%h", obs, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap_stream();
        test_clr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
